// File: rtl/sdp_bram_pkg.sv
// rtl/sdp_bram_pkg.sv - shared types and helpers for the clearing simple-dual-port BRAM
package sdp_bram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int num_bytes(input int width, input int byte_width);
        return width / byte_width;
    endfunction

    function automatic bit width_ok(input int width, input int byte_width);
        return (byte_width > 0) && ((width % byte_width) == 0);
    endfunction

endpackage

// File: rtl/sdp_bram_clr_fsm.sv
// rtl/sdp_bram_clr_fsm.sv - clear-engine FSM sweeping INIT_VALUE over every address
module sdp_bram_clr_fsm
    import sdp_bram_pkg::*;
#(
    parameter int                   RAM_WIDTH     = 16,
    parameter int                   RAM_ADDR_BITS = 9,
    parameter logic [RAM_WIDTH-1:0] INIT_VALUE    = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_req,
    output logic                     busy,
    output logic                     clr_sel,
    output logic [RAM_ADDR_BITS-1:0] clr_addr,
    output logic [RAM_WIDTH-1:0]     clr_data
);

    localparam logic [RAM_ADDR_BITS:0] LAST_ADDR = {1'b0, {RAM_ADDR_BITS{1'b1}}};
    localparam logic [RAM_ADDR_BITS:0] ONE       = {{RAM_ADDR_BITS{1'b0}}, 1'b1};

    state_t                   state;
    state_t                   state_n;
    logic [RAM_ADDR_BITS:0]   cnt;
    logic [RAM_ADDR_BITS:0]   cnt_n;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_n = CLEAR;
                    cnt_n   = '0;
                end
            end
            CLEAR: begin
                cnt_n = cnt + ONE;
                if (cnt == LAST_ADDR) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Reset parks the engine at address 0 in CLEAR; the sweep starts on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            busy  <= (state_n == CLEAR);
        end
    end

    assign clr_sel  = (state == CLEAR);
    assign clr_addr = cnt[RAM_ADDR_BITS-1:0];
    assign clr_data = INIT_VALUE;

endmodule

// File: rtl/sdp_bram_clr.sv
// rtl/sdp_bram_clr.sv - byte-enabled SDP BRAM with write-first bypass and clear engine (option: SDP_BRAM_OUT_REG_EN)
module sdp_bram_clr
    import sdp_bram_pkg::*;
#(
    parameter int                   RAM_WIDTH     = 16,
    parameter int                   RAM_ADDR_BITS = 9,
    parameter int                   BYTE_WIDTH    = 8,
    parameter logic [RAM_WIDTH-1:0] INIT_VALUE    = '0,
    localparam int                  NUM_BYTES     = num_bytes(RAM_WIDTH, BYTE_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic [RAM_ADDR_BITS-1:0] rd_addr,
    output logic [RAM_WIDTH-1:0]     rd_data,
    output logic                     rd_valid,
    input  logic                     write_enable,
    input  logic [RAM_ADDR_BITS-1:0] wr_addr,
    input  logic [RAM_WIDTH-1:0]     wr_data,
    input  logic [NUM_BYTES-1:0]     wr_be,
    input  logic                     clear_req,
    output logic                     busy
);

    localparam int DEPTH = 1 << RAM_ADDR_BITS;

    if (!width_ok(RAM_WIDTH, BYTE_WIDTH)) begin : g_width_check
        $error("sdp_bram_clr: RAM_WIDTH must be a multiple of BYTE_WIDTH");
    end

    logic                     clr_sel;
    logic [RAM_ADDR_BITS-1:0] clr_addr;
    logic [RAM_WIDTH-1:0]     clr_data;

    sdp_bram_clr_fsm #(
        .RAM_WIDTH     (RAM_WIDTH),
        .RAM_ADDR_BITS (RAM_ADDR_BITS),
        .INIT_VALUE    (INIT_VALUE)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_sel   (clr_sel),
        .clr_addr  (clr_addr),
        .clr_data  (clr_data)
    );

    logic [RAM_WIDTH-1:0] mem [DEPTH];

    logic                     user_ok;
    logic                     rd_accept;
    logic                     wr_accept;
    logic [NUM_BYTES-1:0]     mem_we;
    logic [RAM_ADDR_BITS-1:0] mem_addr;
    logic [RAM_WIDTH-1:0]     mem_wdata;
    logic [NUM_BYTES-1:0]     byp_mask;

    assign user_ok   = !busy && !rst;
    assign rd_accept = rd_en && user_ok;
    assign wr_accept = write_enable && user_ok;
    assign byp_mask  = (wr_accept && (wr_addr == rd_addr)) ? wr_be : '0;

    always_comb begin
        mem_we    = '0;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        if (clr_sel) begin
            mem_we    = '1;
            mem_addr  = clr_addr;
            mem_wdata = clr_data;
        end else if (wr_accept) begin
            mem_we    = wr_be;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (mem_we[i]) begin
                mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Array read is read-before-write; colliding lanes are patched from the bypass registers.
    logic [RAM_WIDTH-1:0] ram_q;
    logic [NUM_BYTES-1:0] byp_mask_q;
    logic [RAM_WIDTH-1:0] byp_data_q;
    logic                 vld_q;
    logic [RAM_WIDTH-1:0] merged;

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_q      <= '0;
            byp_mask_q <= '0;
            byp_data_q <= '0;
            vld_q      <= 1'b0;
        end else begin
            vld_q <= rd_accept;
            if (rd_accept) begin
                ram_q      <= mem[rd_addr];
                byp_mask_q <= byp_mask;
                byp_data_q <= wr_data;
            end
        end
    end

    always_comb begin
        merged = ram_q;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (byp_mask_q[i]) begin
                merged[i*BYTE_WIDTH +: BYTE_WIDTH] = byp_data_q[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

`ifdef SDP_BRAM_OUT_REG_EN
    logic [RAM_WIDTH-1:0] out_q;
    logic                 out_vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_vld_q <= vld_q;
            if (vld_q) begin
                out_q <= merged;
            end
        end
    end

    assign rd_data  = out_q;
    assign rd_valid = out_vld_q;
`else
    assign rd_data  = merged;
    assign rd_valid = vld_q;
`endif

endmodule

// File: tb/tb_sdp_bram_clr.sv
// tb/tb_sdp_bram_clr.sv - directed self-checking bench for sdp_bram_clr
module tb_sdp_bram_clr;

`ifdef SDP_BRAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = 512;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0;
    logic [8:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        write_enable = 1'b0;
    logic [8:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [1:0]  wr_be = '0;
    logic        clear_req = 1'b0;
    logic        busy;

    int total = 0;
    int bad = 0;

    sdp_bram_clr dut (
        .clk          (clk),
        .rst          (rst),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .write_enable (write_enable),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_be        (wr_be),
        .clear_req    (clear_req),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Stimulus helpers; all are entered and left at a falling edge.
    task automatic write_word(input logic [8:0] a, input logic [15:0] d, input logic [1:0] be);
        write_enable = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        @(negedge clk);
        write_enable = 1'b0; wr_be = 2'b00;
    endtask

    task automatic read_word(input logic [8:0] a, output logic [15:0] d, output logic v, output logic early);
        rd_en = 1'b1; rd_addr = a; early = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            rd_en = 1'b0;
            if (i < LAT - 1 && rd_valid) early = 1'b1;
        end
        d = rd_data; v = rd_valid;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int cnt;
        logic [15:0] d;
        logic v, e;
        logic [8:0] addrs [3];
        addrs[0] = 9'd0; addrs[1] = 9'd255; addrs[2] = 9'd511;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b exp=1", busy); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
        rst = 1'b0;
        count_busy(cnt);
        total++; if (cnt !== DEPTH) begin bad++; $display("FAIL reset_sweep_len got=%0d exp=%0d", cnt, DEPTH); end
        for (int i = 0; i < 3; i++) begin
            read_word(addrs[i], d, v, e);
            total++; if (v !== 1'b1 || e !== 1'b0) begin bad++; $display("FAIL clear_rd_valid addr=%0d got=%b early=%b exp=1", addrs[i], v, e); end
            total++; if (d !== 16'h0000) begin bad++; $display("FAIL clear_rd_data addr=%0d got=%h exp=0000", addrs[i], d); end
        end
        @(negedge clk);
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL idle_rd_valid got=%b exp=0", rd_valid); end
        total++; if (rd_data !== 16'h0000) begin bad++; $display("FAIL hold_rd_data got=%h exp=0000", rd_data); end
    endtask

    task automatic test_byte_enable;
        logic [15:0] d;
        logic v, e;
        write_word(9'd5, 16'h1234, 2'b11);
        read_word(9'd5, d, v, e);
        total++; if (d !== 16'h1234 || v !== 1'b1) begin bad++; $display("FAIL be_full got=%h v=%b exp=1234", d, v); end
        write_word(9'd5, 16'hABCD, 2'b01);
        read_word(9'd5, d, v, e);
        total++; if (d !== 16'h12CD) begin bad++; $display("FAIL be_low got=%h exp=12CD", d); end
        write_word(9'd5, 16'hEF00, 2'b10);
        read_word(9'd5, d, v, e);
        total++; if (d !== 16'hEFCD) begin bad++; $display("FAIL be_high got=%h exp=EFCD", d); end
        write_word(9'd5, 16'hFFFF, 2'b00);
        read_word(9'd5, d, v, e);
        total++; if (d !== 16'hEFCD) begin bad++; $display("FAIL be_none got=%h exp=EFCD", d); end
        @(negedge clk);
        total++; if (rd_valid !== 1'b0 || rd_data !== 16'hEFCD) begin bad++; $display("FAIL be_hold got=%h v=%b exp=EFCD v=0", rd_data, rd_valid); end
    endtask

    task automatic test_collision;
        logic [15:0] d;
        logic v, e;
        write_enable = 1'b1; wr_addr = 9'd7; wr_data = 16'hBEEF; wr_be = 2'b11;
        read_word(9'd7, d, v, e);
        write_enable = 1'b0; wr_be = 2'b00;
        total++; if (d !== 16'hBEEF || v !== 1'b1) begin bad++; $display("FAIL coll_full got=%h v=%b exp=BEEF", d, v); end
        write_word(9'd8, 16'h1234, 2'b11);
        write_enable = 1'b1; wr_addr = 9'd8; wr_data = 16'hABCD; wr_be = 2'b10;
        read_word(9'd8, d, v, e);
        write_enable = 1'b0; wr_be = 2'b00;
        total++; if (d !== 16'hAB34) begin bad++; $display("FAIL coll_partial got=%h exp=AB34", d); end
        read_word(9'd7, d, v, e);
        total++; if (d !== 16'hBEEF) begin bad++; $display("FAIL coll_stored got=%h exp=BEEF", d); end
        read_word(9'd8, d, v, e);
        total++; if (d !== 16'hAB34) begin bad++; $display("FAIL coll_partial_stored got=%h exp=AB34", d); end
    endtask

    task automatic test_clear_req;
        int cnt;
        logic saw_valid;
        logic [15:0] d;
        logic v, e;
        write_word(9'd10, 16'h5555, 2'b11);
        read_word(9'd10, d, v, e);
        total++; if (d !== 16'h5555) begin bad++; $display("FAIL creq_pre got=%h exp=5555", d); end
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        rd_en = 1'b1; rd_addr = 9'd10;
        saw_valid = 1'b0;
        cnt = 0;
        while (busy && cnt < 2000) begin
            if (rd_valid) saw_valid = 1'b1;
            if (cnt == 100) clear_req = 1'b1;
            else clear_req = 1'b0;
            cnt++;
            @(negedge clk);
        end
        rd_en = 1'b0; clear_req = 1'b0;
        total++; if (cnt !== DEPTH) begin bad++; $display("FAIL creq_sweep_len got=%0d exp=%0d", cnt, DEPTH); end
        total++; if (saw_valid !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL creq_busy_read got=%b exp=0", saw_valid | rd_valid); end
        read_word(9'd10, d, v, e);
        total++; if (d !== 16'h0000 || v !== 1'b1) begin bad++; $display("FAIL creq_post got=%h v=%b exp=0000", d, v); end
    endtask

    task automatic test_reset_mid_sweep;
        int cnt;
        logic [15:0] d;
        logic v, e;
        write_word(9'd400, 16'h4321, 2'b11);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        repeat (200) @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", busy); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        count_busy(cnt);
        total++; if (cnt !== DEPTH) begin bad++; $display("FAIL mid_restart_len got=%0d exp=%0d", cnt, DEPTH); end
        read_word(9'd400, d, v, e);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL mid_cleared got=%h exp=0000", d); end
        write_word(9'd30, 16'h00FF, 2'b11);
        rd_en = 1'b1; rd_addr = 9'd30; rst = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        total++; if (rd_valid !== 1'b0 || rd_data !== 16'h0000) begin bad++; $display("FAIL squash got=%h v=%b exp=0000 v=0", rd_data, rd_valid); end
        rst = 1'b0;
        count_busy(cnt);
        total++; if (cnt !== DEPTH) begin bad++; $display("FAIL squash_sweep_len got=%0d exp=%0d", cnt, DEPTH); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] vals [4];
        logic [15:0] d;
        logic v, e;
        int j;
        vals[0] = 16'h00FF; vals[1] = 16'hA5A5; vals[2] = 16'h0F0F; vals[3] = 16'hC3C3;
        for (int i = 0; i < 4; i++) write_word(9'(20 + i), vals[i], 2'b11);
        read_word(9'd20, d, v, e);
        total++; if (d !== 16'h00FF || v !== 1'b1 || e !== 1'b0) begin bad++; $display("FAIL latency got=%h v=%b early=%b exp=00FF v=1", d, v, e); end
        @(negedge clk);
        rd_en = 1'b1; rd_addr = 9'd20;
        for (int i = 0; i < 4 + LAT; i++) begin
            @(negedge clk);
            j = i - (LAT - 1);
            if (j >= 0 && j < 4) begin
                total++; if (rd_valid !== 1'b1 || rd_data !== vals[j]) begin bad++; $display("FAIL stream idx=%0d got=%h v=%b exp=%h", j, rd_data, rd_valid, vals[j]); end
            end else begin
                total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL stream_gap cyc=%0d got=%b exp=0", i, rd_valid); end
            end
            if (i < 3) rd_addr = 9'(21 + i);
            else rd_en = 1'b0;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_byte_enable();
        test_collision();
        test_clear_req();
        test_reset_mid_sweep();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
